// File: rtl/int_dot_mac.sv
// rtl/int_dot_mac.sv - pipelined integer dot-product accumulator with saturation and valid/ready flow control
module int_dot_mac #(
    parameter int LANES   = 64,
    parameter int ELEM_W  = 4,
    parameter int ACC_W   = 24,
    parameter int SCALE_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*ELEM_W-1:0]   in_a,
    input  logic [LANES*ELEM_W-1:0]   in_b,
    input  logic                      in_signed,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic [SCALE_W-1:0]        in_a_scale,
    input  logic [SCALE_W-1:0]        in_b_scale,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          out_acc,
    output logic                      out_sat,
    output logic [SCALE_W-1:0]        out_a_scale,
    output logic [SCALE_W-1:0]        out_b_scale
);
    localparam int LOG2_L = $clog2(LANES);
    localparam int PROD_W = 2 * ELEM_W;
    localparam int SUM_W  = PROD_W + LOG2_L;

    logic w_adv, w_accept;
    assign w_adv    = !(out_valid && !out_ready);
    assign in_ready = w_adv && !rst;
    assign w_accept = in_valid && in_ready;

    // Group mode/scales are taken from the first beat; later beats reuse the latched copy.
    logic               r_grp_signed;
    logic [SCALE_W-1:0] r_grp_a_scale, r_grp_b_scale;
    logic               w_mode;
    logic [SCALE_W-1:0] w_a_scale, w_b_scale;
    assign w_mode    = in_first ? in_signed  : r_grp_signed;
    assign w_a_scale = in_first ? in_a_scale : r_grp_a_scale;
    assign w_b_scale = in_first ? in_b_scale : r_grp_b_scale;

    logic [PROD_W-1:0] w_prod [LANES];
    logic [PROD_W-1:0] w_ea, w_eb;
    always_comb begin
        w_ea = '0;
        w_eb = '0;
        for (int j = 0; j < LANES; j++) begin
            w_ea = {{ELEM_W{w_mode & in_a[j*ELEM_W+ELEM_W-1]}}, in_a[j*ELEM_W +: ELEM_W]};
            w_eb = {{ELEM_W{w_mode & in_b[j*ELEM_W+ELEM_W-1]}}, in_b[j*ELEM_W +: ELEM_W]};
            w_prod[j] = w_ea * w_eb;
        end
    end

    logic               r_s1_valid, r_s1_first, r_s1_last, r_s1_signed;
    logic [SCALE_W-1:0] r_s1_a_scale, r_s1_b_scale;
    logic [PROD_W-1:0]  r_s1_prod [LANES];

    logic [SUM_W-1:0] w_sum;
    always_comb begin
        w_sum = '0;
        for (int j = 0; j < LANES; j++)
            w_sum = w_sum + {{LOG2_L{r_s1_signed & r_s1_prod[j][PROD_W-1]}}, r_s1_prod[j]};
    end

    logic               r_s2_valid, r_s2_first, r_s2_last, r_s2_signed;
    logic [SCALE_W-1:0] r_s2_a_scale, r_s2_b_scale;
    logic [ACC_W-1:0]   r_s2_sum;
    logic [ACC_W-1:0]   r_acc;
    logic               r_sticky;

    // One guard bit is enough to detect overflow of a single ACC_W-bit addition.
    logic [ACC_W:0]   w_acc_ext, w_sum_ext, w_next;
    logic             w_ovf, w_sticky;
    logic [ACC_W-1:0] w_clamp, w_sat_val;
    always_comb begin
        w_acc_ext = {r_s2_signed & r_acc[ACC_W-1], r_acc};
        w_sum_ext = {r_s2_signed & r_s2_sum[ACC_W-1], r_s2_sum};
        w_next    = r_s2_first ? w_sum_ext : w_acc_ext + w_sum_ext;
        if (r_s2_signed) begin
            w_ovf   = w_next[ACC_W] ^ w_next[ACC_W-1];
            w_clamp = w_next[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            w_ovf   = w_next[ACC_W];
            w_clamp = {ACC_W{1'b1}};
        end
        w_sat_val = w_ovf ? w_clamp : w_next[ACC_W-1:0];
        w_sticky  = (r_s2_first ? 1'b0 : r_sticky) | w_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grp_signed  <= 1'b0;
            r_grp_a_scale <= '0;
            r_grp_b_scale <= '0;
            r_s1_valid    <= 1'b0;
            r_s2_valid    <= 1'b0;
            r_acc         <= '0;
            r_sticky      <= 1'b0;
            out_valid     <= 1'b0;
            out_acc       <= '0;
            out_sat       <= 1'b0;
            out_a_scale   <= '0;
            out_b_scale   <= '0;
        end else if (w_adv) begin
            if (w_accept && in_first) begin
                r_grp_signed  <= in_signed;
                r_grp_a_scale <= in_a_scale;
                r_grp_b_scale <= in_b_scale;
            end
            r_s1_valid   <= w_accept;
            r_s1_first   <= in_first;
            r_s1_last    <= in_last;
            r_s1_signed  <= w_mode;
            r_s1_a_scale <= w_a_scale;
            r_s1_b_scale <= w_b_scale;
            r_s1_prod    <= w_prod;

            r_s2_valid   <= r_s1_valid;
            r_s2_first   <= r_s1_first;
            r_s2_last    <= r_s1_last;
            r_s2_signed  <= r_s1_signed;
            r_s2_a_scale <= r_s1_a_scale;
            r_s2_b_scale <= r_s1_b_scale;
            r_s2_sum     <= {{(ACC_W-SUM_W){r_s1_signed & w_sum[SUM_W-1]}}, w_sum};

            if (r_s2_valid) begin
                r_acc    <= w_sat_val;
                r_sticky <= w_sticky;
            end
            // With adv high, a pending result is being consumed this cycle.
            if (r_s2_valid && r_s2_last) begin
                out_valid   <= 1'b1;
                out_acc     <= w_sat_val;
                out_sat     <= w_sticky;
                out_a_scale <= r_s2_a_scale;
                out_b_scale <= r_s2_b_scale;
            end else begin
                out_valid   <= 1'b0;
            end
        end
    end
endmodule

// File: doc/int_dot_mac.md
# int_dot_mac

Pipelined, parametrised integer dot-product accumulator for the matrix datapath. Each accepted beat multiplies `LANES` element pairs and reduces them to one sum. Beats are accumulated across a group delimited by `in_first`/`in_last`. The block supports signed or unsigned element mode, saturating accumulation, per-group scale pass-through and valid/ready flow control on both sides.

## Interface
- `LANES`, 64, element pairs per beat; power of two, ≥2
- `ELEM_W`, 4, element width in bits (4 or 8 supported)
- `ACC_W`, 24, accumulator/result width; must be ≥ 2*ELEM_W + log2(LANES) + 1
- `SCALE_W`, 8, width of each scale-factor field
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  beat valid
- `in_ready`  out  1  block can accept a beat
- `in_a`, `in_b`  in  LANES*ELEM_W  element vectors; element j at bits [j*ELEM_W +: ELEM_W]
- `in_signed`  in  1  1 = two's-complement elements, 0 = unsigned
- `in_first`  in  1  beat starts a new group (discard previous accumulator)
- `in_last`  in  1  beat ends the group (emit result)
- `in_a_scale`, `in_b_scale`  in  SCALE_W  group scale factors, sampled on the first beat
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `out_acc`  out  ACC_W  group result, two's-complement in signed mode
- `out_sat`  out  1  saturation occurred at any point in the group (sticky)
- `out_a_scale`, `out_b_scale`  out  SCALE_W  scales captured with this group

## Operation
- Global advance enable: `adv = !(out_valid && !out_ready)`.
- `in_ready = adv && !rst`. Beat accepted when `in_valid && in_ready`.
- S1 (product stage): register LANES products, each 2*ELEM_W bits. Operands are sign-extended if `in_signed`, else zero-extended. The stage also registers valid, first, last, signed and the scales.
- S2 (reduce stage): register the adder-tree sum, width SUM_W = 2*ELEM_W + log2(LANES), sign- or zero-extended to ACC_W.
- S3 (accumulate stage): next = first ? sum : acc + sum, computed at ACC_W+1 bits.
  - Saturation bounds, signed: [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Unsigned: [0, 2^ACC_W-1].
  - On clamp, set the sticky sat flag. The flag clears on a first beat, then takes that beat's own clamp result.
- Mode and scales are latched from the group's first beat. `in_signed` on later beats of the group is ignored.
- On a last beat at S3: load `out_acc` with the saturated result, `out_sat` with the sticky flag, and the scales; set `out_valid=1`.
  - A beat with both `in_first` and `in_last` set is a single-beat group.
- `out_valid` clears on `out_ready` unless a new last beat reaches S3 in the same cycle. That beat overwrites the output and `out_valid` stays 1.
- Beats without `in_last` only update the accumulator; they never raise `out_valid`.
- A beat without `in_first` that arrives after reset or after a completed group accumulates onto the current accumulator value. After reset that value is 0.
- When `adv=0`, all stages, the accumulator and the outputs hold.

## Timing
- Reset values: `out_valid=0`, `out_acc=0`, `out_sat=0`, both `out_*_scale=0`, `in_ready=0` while `rst=1`. Stage valids, accumulator, sticky flag and latched mode are all cleared.
- Latency: a last beat accepted at cycle t gives `out_valid=1` at t+3 when `adv` is continuously 1. Each stall cycle adds one cycle.
- Throughput: one beat per cycle while `adv=1`.
- Stall: `out_valid && !out_ready` drops `in_ready` in the same cycle (combinational). Nothing in flight is lost or duplicated.
- Reset mid-group: the in-flight group is discarded and no partial result is emitted. The first beat accepted after reset is processed normally.
- `in_valid=0` bubbles propagate as invalid stages and never modify the accumulator.

## Test plan
- Unsigned, defaults: single beat, first=last=1, all a=b=4'hF → `out_acc=14400` (0x003840) at t+3, `out_sat=0`.
- Signed: single beat, all a=4'h8 (-8), b=4'h7 → `out_acc=0xFFF200` (-3584). All a=b=4'h8 → `out_acc=4096`.
- Accumulate: 3 back-to-back unsigned beats of all 4'hF, first on beat 0, last on beat 2; `in_a_scale=8'h12`, `in_b_scale=8'h34` on beat 0, different values on later beats → one result `out_acc=43200` three cycles after the last beat, scales 0x12/0x34, `out_valid` low before that.
- Saturation with ACC_W=16:
  - Unsigned: 5 beats of all 4'hF → `out_acc=0xFFFF`, `out_sat=1`.
  - Signed: 11 beats of a=b=4'h7 → `out_acc=0x7FFF`, `out_sat=1`.
  - Next single-beat group → `out_sat=0`.
- Backpressure: two single-beat groups (14400, then 3136) with `out_ready=0` → first result holds, `in_ready=0`, second result appears only after `out_ready` is pulsed. Both are delivered in order, exactly once.
- Reset: assert `rst` for 1 cycle mid-group after 2 beats → no `out_valid`. A new single-beat group of 4'hF gives 14400, not an accumulated value.
